home_event_scheduler: RTL and testbench

Front-end sequencer for the home automation FSM: synchronizes and debounces the four raw binary sensor lines, latches their rising edges as pending events, and offers them to the FSM one at a time over a valid/ack handshake in fixed priority order. It also registers the temperature sample and derives hysteretic cooler/heater requests. It sits between the sensor pins and the home automation FSM, which consumes the events and the level outputs.

---
 rtl/home_pkg.sv | 49 ++++
 rtl/sensor_debounce.sv | 48 ++++
 rtl/home_event_scheduler.sv | 157 +++++++++++++++
 tb/tb_home_event_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/home_pkg.sv
// home_pkg: event codes, scheduler states and default climate thresholds shared by
// the home automation front end.
package home_pkg;

    typedef enum logic [2:0] {
        NONE   = 3'd0,
        FIRE   = 3'd1,
        FRONT  = 3'd2,
        REAR   = 3'd3,
        WINDOW = 3'd4
    } evt_code_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        GAP   = 2'd2
    } sched_state_t;

    localparam int         N_SRC        = 4;
    localparam logic [7:0] COOL_ON_DEF  = 8'd30;
    localparam logic [7:0] COOL_OFF_DEF = 8'd28;
    localparam logic [7:0] HEAT_ON_DEF  = 8'd15;
    localparam logic [7:0] HEAT_OFF_DEF = 8'd17;

    // Pending bits are ordered {window, rear, front, fire}; the lowest set bit wins.
    function automatic evt_code_t prio_code(input logic [3:0] pend);
        evt_code_t code;
        code = NONE;
        if (pend[0])      code = FIRE;
        else if (pend[1]) code = FRONT;
        else if (pend[2]) code = REAR;
        else if (pend[3]) code = WINDOW;
        return code;
    endfunction

    function automatic logic [3:0] code_onehot(input evt_code_t code);
        logic [3:0] mask;
        mask = 4'b0000;
        case (code)
            FIRE:    mask = 4'b0001;
            FRONT:   mask = 4'b0010;
            REAR:    mask = 4'b0100;
            WINDOW:  mask = 4'b1000;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: two-flop synchronizer followed by a run-length debouncer; rise
// pulses on the same edge the debounced level goes high.
module sensor_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [8:0] DB_TC = 9'(DB_CYCLES);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_level;
    logic [7:0] r_cnt;
    logic       w_diff;
    logic       w_tc;

    assign w_diff = r_sync2 ^ r_level;
    assign w_tc   = w_diff && (({1'b0, r_cnt} + 9'd1) == DB_TC);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= 8'd0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (!w_diff) begin
                r_cnt <= 8'd0;
            end else if (w_tc) begin
                r_cnt   <= 8'd0;
                r_level <= ~r_level;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign level = r_level;
    assign rise  = w_tc & ~r_level;

endmodule

// File: rtl/home_event_scheduler.sv
// home_event_scheduler: debounces four sensor lines, queues their rising edges and
// offers them one at a time to the home FSM; also tracks temperature with hysteresis.
//
// state | meaning
// IDLE  | waiting for any pending bit
// OFFER | evtValid high, evtCode frozen until evtAck
// GAP   | enforced quiet time after an accepted event
module home_event_scheduler
    import home_pkg::*;
#(
    parameter int         DB_CYCLES  = 4,
    parameter int         GAP_CYCLES = 2,
    parameter logic [7:0] COOL_ON    = COOL_ON_DEF,
    parameter logic [7:0] COOL_OFF   = COOL_OFF_DEF,
    parameter logic [7:0] HEAT_ON    = HEAT_ON_DEF,
    parameter logic [7:0] HEAT_OFF   = HEAT_OFF_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frontRaw,
    input  logic       rearRaw,
    input  logic       windowRaw,
    input  logic       fireRaw,
    input  logic [7:0] tempRaw,
    input  logic       tempValid,
    input  logic       evtAck,
    output logic       evtValid,
    output logic [2:0] evtCode,
    output logic       frontSens,
    output logic       rearSens,
    output logic       windowSens,
    output logic       fireSens,
    output logic [7:0] tempSens,
    output logic       coolReq,
    output logic       heatReq,
    output logic [3:0] pending,
    output logic       overflow
);

    localparam bit         HAS_GAP  = (GAP_CYCLES > 0);
    localparam logic [7:0] GAP_LOAD = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

    logic [3:0]   w_raw;
    logic [3:0]   w_level;
    logic [3:0]   w_rise;

    sched_state_t r_state;
    sched_state_t w_state_nxt;
    evt_code_t    r_code;
    evt_code_t    w_code_nxt;
    logic [7:0]   r_gap_cnt;
    logic [7:0]   w_gap_nxt;

    logic [3:0]   r_pending;
    logic [3:0]   w_clr;
    logic [3:0]   w_pending_nxt;
    logic         r_overflow;
    logic         w_lost;

    logic [7:0]   r_temp;
    logic         r_cool;
    logic         r_heat;
    logic         w_cool_nxt;
    logic         w_heat_nxt;

    assign w_raw = {windowRaw, rearRaw, frontRaw, fireRaw};

    for (genvar g = 0; g < N_SRC; g++) begin : g_db
        sensor_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .raw  (w_raw[g]),
            .level(w_level[g]),
            .rise (w_rise[g])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_gap_nxt   = r_gap_cnt;
        w_clr       = 4'b0000;
        case (r_state)
            IDLE: begin
                if (r_pending != 4'b0000) begin
                    w_code_nxt  = prio_code(r_pending);
                    w_state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (evtAck) begin
                    w_clr = code_onehot(r_code);
                    if (HAS_GAP) begin
                        w_state_nxt = GAP;
                        w_gap_nxt   = GAP_LOAD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                if (r_gap_cnt == 8'd0) w_state_nxt = IDLE;
                else                   w_gap_nxt   = r_gap_cnt - 8'd1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A new rise on a bit that is being acked this edge re-arms it instead of being lost.
    assign w_pending_nxt = (r_pending & ~w_clr) | w_rise;
    assign w_lost        = |(w_rise & r_pending & ~w_clr);

    always_comb begin
        w_cool_nxt = r_cool;
        w_heat_nxt = r_heat;
        if (tempValid) begin
            if (tempRaw >= COOL_ON)       w_cool_nxt = 1'b1;
            else if (tempRaw <= COOL_OFF) w_cool_nxt = 1'b0;
            if (tempRaw <= HEAT_ON)       w_heat_nxt = 1'b1;
            else if (tempRaw >= HEAT_OFF) w_heat_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_code     <= NONE;
            r_gap_cnt  <= 8'd0;
            r_pending  <= 4'b0000;
            r_overflow <= 1'b0;
            r_temp     <= 8'd0;
            r_cool     <= 1'b0;
            r_heat     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_code     <= w_code_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_pending  <= w_pending_nxt;
            r_overflow <= r_overflow | w_lost;
            r_cool     <= w_cool_nxt;
            r_heat     <= w_heat_nxt;
            if (tempValid) r_temp <= tempRaw;
        end
    end

    assign evtValid = (r_state == OFFER);
    assign evtCode  = evtValid ? r_code : NONE;
    assign {windowSens, rearSens, frontSens, fireSens} = w_level;
    assign tempSens = r_temp;
    assign coolReq  = r_cool;
    assign heatReq  = r_heat;
    assign pending  = r_pending;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_home_event_scheduler.sv
// tb_home_event_scheduler: directed scenarios with literal expectations plus randomized
// traffic, all cross-checked every cycle against a cycle-level behavioural model.
module tb_home_event_scheduler;

    localparam int DB  = 4;
    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       front_raw, rear_raw, window_raw, fire_raw;
    logic [7:0] temp_raw;
    logic       temp_valid;
    logic       evt_ack;
    logic       evtValid;
    logic [2:0] evtCode;
    logic       frontSens, rearSens, windowSens, fireSens;
    logic [7:0] tempSens;
    logic       coolReq, heatReq;
    logic [3:0] pending;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int n_print = 0;
    bit cmp_en  = 1'b0;

    home_event_scheduler #(
        .DB_CYCLES(DB),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst(rst),
        .frontRaw(front_raw), .rearRaw(rear_raw), .windowRaw(window_raw), .fireRaw(fire_raw),
        .tempRaw(temp_raw), .tempValid(temp_valid), .evtAck(evt_ack),
        .evtValid(evtValid), .evtCode(evtCode),
        .frontSens(frontSens), .rearSens(rearSens), .windowSens(windowSens), .fireSens(fireSens),
        .tempSens(tempSens), .coolReq(coolReq), .heatReq(heatReq),
        .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Model state: sync delay line, debounced levels with disagreement run lengths,
    // pending set, the event on offer (0 = none) and the quiet cycles still owed.
    typedef struct packed {
        logic [3:0]      s1;
        logic [3:0]      s2;
        logic [3:0]      lvl;
        logic [3:0][7:0] run;
        logic [3:0]      pend;
        logic            ovf;
        logic [2:0]      offer;
        logic [7:0]      wait_n;
        logic [7:0]      temp;
        logic            cool;
        logic            heat;
    } mstate_t;

    mstate_t m = '0;

    function automatic mstate_t model_next(input mstate_t c, input logic r, input logic [3:0] raw,
                                           input logic tv, input logic [7:0] tr, input logic ack);
        mstate_t    n;
        logic [3:0] rise;
        logic [3:0] clr;
        n    = c;
        rise = '0;
        clr  = '0;
        if (r) begin
            n = '0;
        end else begin
            n.s1 = raw;
            n.s2 = c.s1;
            for (int i = 0; i < 4; i++) begin
                if (c.s2[i] == c.lvl[i]) begin
                    n.run[i] = 8'd0;
                end else if (int'(c.run[i]) + 1 >= DB) begin
                    n.lvl[i] = c.s2[i];
                    n.run[i] = 8'd0;
                    rise[i]  = c.s2[i];
                end else begin
                    n.run[i] = c.run[i] + 8'd1;
                end
            end
            if (c.offer != 3'd0) begin
                if (ack) begin
                    clr      = 4'(4'b0001 << (c.offer - 3'd1));
                    n.offer  = 3'd0;
                    n.wait_n = 8'(GAP);
                end
            end else if (c.wait_n != 8'd0) begin
                n.wait_n = c.wait_n - 8'd1;
            end else if (c.pend != 4'd0) begin
                for (int i = 3; i >= 0; i--) if (c.pend[i]) n.offer = 3'(i + 1);
            end
            n.pend = (c.pend & ~clr) | rise;
            if ((rise & c.pend & ~clr) != 4'd0) n.ovf = 1'b1;
            if (tv) begin
                n.temp = tr;
                if (tr >= 8'd30)      n.cool = 1'b1;
                else if (tr <= 8'd28) n.cool = 1'b0;
                if (tr <= 8'd15)      n.heat = 1'b1;
                else if (tr >= 8'd17) n.heat = 1'b0;
            end
        end
        return n;
    endfunction

    always @(posedge clk)
        m <= model_next(m, rst, {window_raw, rear_raw, front_raw, fire_raw},
                        temp_valid, temp_raw, evt_ack);

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_print < 40) begin
                n_print++;
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_valid", int'(evtValid), int'(m.offer != 3'd0));
            check("m_code", int'(evtCode), int'(m.offer));
            check("m_sens", int'({windowSens, rearSens, frontSens, fireSens}), int'(m.lvl));
            check("m_pend", int'(pending), int'(m.pend));
            check("m_ovf", int'(overflow), int'(m.ovf));
            check("m_temp", int'(tempSens), int'(m.temp));
            check("m_clim", int'({coolReq, heatReq}), int'({m.cool, m.heat}));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_one();
        evt_ack = 1'b1;
        @(negedge clk);
        evt_ack = 1'b0;
    endtask

    task automatic wait_valid(input int max_c, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < max_c && !seen; c++) begin
            @(negedge clk);
            seen = evtValid;
        end
    endtask

    int         got_code[3];
    int         got_cyc[3];
    int         n_got;
    bit         seen;
    int         hold[4];
    logic [3:0] rv;
    int         hys_t[8]    = '{29, 30, 29, 28, 16, 15, 16, 17};
    int         hys_cool[8] = '{0, 1, 1, 0, 0, 0, 0, 0};
    int         hys_heat[8] = '{0, 0, 0, 0, 0, 1, 1, 0};

    initial begin
        rst = 1'b1;
        front_raw = 1'b0; rear_raw = 1'b0; window_raw = 1'b0; fire_raw = 1'b1;
        temp_raw = 8'd0; temp_valid = 1'b0; evt_ack = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        check("rst_valid", int'(evtValid), 0);
        check("rst_code", int'(evtCode), 0);
        check("rst_pend", int'(pending), 0);
        check("rst_sens", int'({windowSens, rearSens, frontSens, fireSens}), 0);
        check("rst_temp", int'({tempSens, coolReq, heatReq, overflow}), 0);
        rst = 1'b0;
        cyc(6);
        check("rst_lat_early", int'(evtValid), 0);
        cyc(1);
        check("rst_lat_valid", int'(evtValid), 1);
        check("rst_lat_code", int'(evtCode), 1);
        ack_one();
        check("ack_drop", int'(evtValid), 0);
        fire_raw = 1'b0;
        cyc(12);

        // glitch of 3 cycles, then a real 0->1
        front_raw = 1'b1; cyc(3); front_raw = 1'b0; cyc(10);
        check("glitch_sens", int'(frontSens), 0);
        check("glitch_pend", int'(pending), 0);
        front_raw = 1'b1;
        cyc(5);
        check("db_early", int'(frontSens), 0);
        cyc(1);
        check("db_edge6", int'(frontSens), 1);
        check("db_pend", int'(pending), 2);
        cyc(1);
        check("db_code", int'(evtCode), 2);
        ack_one();
        front_raw = 1'b0;
        cyc(12);

        // simultaneous arrivals with ack tied high
        front_raw = 1'b1; rear_raw = 1'b1; window_raw = 1'b1; evt_ack = 1'b1;
        n_got = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (evtValid && n_got < 3) begin
                got_code[n_got] = int'(evtCode);
                got_cyc[n_got]  = c;
                n_got++;
            end
        end
        evt_ack = 1'b0;
        check("prio_count", n_got, 3);
        check("prio_first_cyc", got_cyc[0], 7);
        check("prio_code0", got_code[0], 2);
        check("prio_code1", got_code[1], 3);
        check("prio_code2", got_code[2], 4);
        check("prio_space01", got_cyc[1] - got_cyc[0], 4);
        check("prio_space12", got_cyc[2] - got_cyc[1], 4);
        front_raw = 1'b0; rear_raw = 1'b0; window_raw = 1'b0;
        cyc(12);

        // stall: fire arrives while rear is on offer
        rear_raw = 1'b1;
        cyc(7);
        check("stall_code_rear", int'(evtCode), 3);
        fire_raw = 1'b1;
        cyc(12);
        check("stall_hold_valid", int'(evtValid), 1);
        check("stall_hold_code", int'(evtCode), 3);
        check("stall_pend", int'(pending), 5);
        ack_one();
        check("stall_drop", int'(evtValid), 0);
        wait_valid(8, seen);
        check("stall_next_seen", int'(seen), 1);
        check("stall_next_code", int'(evtCode), 1);
        ack_one();
        fire_raw = 1'b0; rear_raw = 1'b0;
        cyc(12);

        // overflow: second rear rise while the first is still unacked
        rear_raw = 1'b1;
        cyc(7);
        check("ovf_code", int'(evtCode), 3);
        rear_raw = 1'b0; cyc(8);
        rear_raw = 1'b1; cyc(8);
        check("ovf_set", int'(overflow), 1);
        check("ovf_pend2", int'(pending[2]), 1);
        ack_one();
        cyc(4);
        check("ovf_sticky", int'(overflow), 1);
        check("ovf_pend_clr", int'(pending), 0);
        rear_raw = 1'b0;
        cyc(12);

        // reset while offering: event dropped, line still high re-arms afterwards
        window_raw = 1'b1;
        cyc(7);
        check("rof_code", int'(evtCode), 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rof_valid", int'(evtValid), 0);
        check("rof_ovf", int'(overflow), 0);
        check("rof_pend", int'(pending), 0);
        cyc(7);
        check("rof_reoffer", int'(evtCode), 4);
        ack_one();
        window_raw = 1'b0;
        cyc(12);

        // temperature hysteresis
        temp_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            temp_raw = 8'(hys_t[i]);
            @(negedge clk);
            check("hys_temp", int'(tempSens), hys_t[i]);
            check("hys_cool", int'(coolReq), hys_cool[i]);
            check("hys_heat", int'(heatReq), hys_heat[i]);
        end
        temp_valid = 1'b0;

        // randomized traffic, checked by the per-cycle model compare
        rv = 4'b0000;
        for (int i = 0; i < 4; i++) hold[i] = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                hold[i]--;
                if (hold[i] == 0) begin
                    rv[i]   = ~rv[i];
                    hold[i] = int'($urandom_range(1, 10));
                end
            end
            {window_raw, rear_raw, front_raw, fire_raw} = rv;
            evt_ack    = ($urandom_range(0, 1) == 1);
            temp_valid = ($urandom_range(0, 3) == 0);
            temp_raw   = 8'($urandom_range(5, 40));
            rst        = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        rst = 1'b0; evt_ack = 1'b0; temp_valid = 1'b0;
        {window_raw, rear_raw, front_raw, fire_raw} = 4'b0000;
        cyc(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
